// File: rtl/multicycle_ctrl_hs.sv
// multicycle_ctrl_hs
//   Main control FSM for the multicycle MIPS datapath. Sequences
//   IF -> PCINC -> ID -> EX -> (MEM) -> (WB) -> IF. IF and MEM stall on
//   mem_ready when MEM_HANDSHAKE is set. Supports jal/jr/bgtz and
//   zero-extended logical immediates. op=111111 parks the FSM in a sticky
//   HALT state. A counter tracks retired instructions.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   op, funct           : IR[31:26], IR[5:0]
//   mem_ready           : memory access completes this cycle
//   PCSrc, ALUSrcA, ALUSrcB, lorD, MemRead, MemWrite, MemtoReg, RegDst,
//   IRWrite, RegWrite, PCWrite, Branch, ExtSel, Zero_Ctr, ALUop, Funct_im
//                       : datapath controls, registered
//   halted              : FSM is in HALT
//   state               : current state encoding
//   retired             : completed-instruction count (wraps)
module multicycle_ctrl_hs #(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned FUNCT_IM_W    = 3,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic                  mem_ready,
  output logic [1:0]            PCSrc,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic                  lorD,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [1:0]            MemtoReg,
  output logic [1:0]            RegDst,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic                  PCWrite,
  output logic                  Branch,
  output logic                  ExtSel,
  output logic                  Zero_Ctr,
  output logic [1:0]            ALUop,
  output logic [FUNCT_IM_W-1:0] Funct_im,
  output logic                  halted,
  output logic [2:0]            state,
  output logic [CNT_W-1:0]      retired
);

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_PCINC = 3'd1,
    S_ID    = 3'd2,
    S_EX    = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_ready;
  logic w_lw, w_sw, w_rfmt, w_jr, w_rtype, w_imm;
  logic w_beq, w_bne, w_bgtz, w_j, w_jal, w_halt_op;
  logic [FUNCT_IM_W-1:0] w_imm_fim;

  logic [1:0]            w_pcsrc;
  logic                  w_asa;
  logic [1:0]            w_asb;
  logic                  w_lord, w_mr, w_mw;
  logic [1:0]            w_m2r, w_rdst;
  logic                  w_irw, w_rw, w_pcw, w_br, w_ext, w_zc;
  logic [1:0]            w_aluop;
  logic [FUNCT_IM_W-1:0] w_fim;
  logic                  w_hlt;
  logic                  w_retire;

  assign w_ready   = mem_ready | (MEM_HANDSHAKE == 0);

  assign w_lw      = (op == 6'b100011);
  assign w_sw      = (op == 6'b101011);
  assign w_rfmt    = (op == 6'b000000);
  assign w_jr      = w_rfmt & (funct == 6'b001000);
  assign w_rtype   = w_rfmt & ~w_jr;
  assign w_beq     = (op == 6'b000100);
  assign w_bne     = (op == 6'b000101);
  assign w_bgtz    = (op == 6'b000111);
  assign w_j       = (op == 6'b000010);
  assign w_jal     = (op == 6'b000011);
  assign w_halt_op = (op == 6'b111111);

  always_comb begin
    w_imm     = 1'b1;
    w_imm_fim = '0;
    case (op)
      6'b001000: w_imm_fim = FUNCT_IM_W'(0);  // addi
      6'b001100: w_imm_fim = FUNCT_IM_W'(1);  // andi
      6'b001101: w_imm_fim = FUNCT_IM_W'(2);  // ori
      6'b001110: w_imm_fim = FUNCT_IM_W'(3);  // xori
      6'b001010: w_imm_fim = FUNCT_IM_W'(4);  // slti
      default:   w_imm     = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:    w_next = w_ready ? S_PCINC : S_IF;
      S_PCINC: w_next = S_ID;
      S_ID:    w_next = w_halt_op ? S_HALT : S_EX;
      S_EX: begin
        if (w_lw | w_sw)          w_next = S_MEM;
        else if (w_rtype | w_imm) w_next = S_WB;
        else                      w_next = S_IF;
      end
      S_MEM: begin
        if (!w_ready)  w_next = S_MEM;
        else if (w_lw) w_next = S_WB;
        else           w_next = S_IF;
      end
      S_WB:    w_next = S_IF;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IF;  // illegal code 7 recovers
    endcase
  end

  // Outputs are decoded from the state being entered and registered, so a
  // stall cycle re-registers the same values.
  always_comb begin
    w_pcsrc = '0;
    w_asa   = 1'b0;
    w_asb   = 2'b01;
    w_lord  = 1'b0;
    w_mr    = 1'b0;
    w_mw    = 1'b0;
    w_m2r   = '0;
    w_rdst  = '0;
    w_irw   = 1'b0;
    w_rw    = 1'b0;
    w_pcw   = 1'b0;
    w_br    = 1'b0;
    w_ext   = 1'b0;
    w_zc    = 1'b0;
    w_aluop = '0;
    w_fim   = '0;
    w_hlt   = 1'b0;
    case (w_next)
      S_IF: w_mr = 1'b1;
      S_PCINC: begin
        w_pcw = 1'b1;
        w_irw = 1'b1;
      end
      S_ID: begin
        w_asb = 2'b11;
        w_ext = 1'b1;
      end
      S_EX: begin
        if (w_lw | w_sw) begin
          w_asa = 1'b1;
          w_asb = 2'b10;
          w_ext = 1'b1;
        end else if (w_rtype) begin
          w_asa   = 1'b1;
          w_asb   = 2'b00;
          w_aluop = 2'b10;
        end else if (w_imm) begin
          w_asa   = 1'b1;
          w_asb   = 2'b10;
          w_aluop = 2'b11;
          w_fim   = w_imm_fim;
          w_ext   = (op == 6'b001000) | (op == 6'b001010);
        end else if (w_beq | w_bne | w_bgtz) begin
          w_asa   = 1'b1;
          w_asb   = 2'b00;
          w_pcsrc = 2'b01;
          w_br    = 1'b1;
          w_zc    = w_beq;
          w_aluop = w_bgtz ? 2'b11 : 2'b01;
          w_fim   = w_bgtz ? FUNCT_IM_W'(5) : '0;
        end else if (w_j | w_jal) begin
          w_pcsrc = 2'b10;
          w_pcw   = 1'b1;
          if (w_jal) begin
            w_rw   = 1'b1;
            w_rdst = 2'b10;
            w_m2r  = 2'b10;
          end
        end else if (w_jr) begin
          w_pcsrc = 2'b11;
          w_pcw   = 1'b1;
        end
      end
      S_MEM: begin
        w_lord = 1'b1;
        w_mr   = w_lw;
        w_mw   = w_sw;
      end
      S_WB: begin
        w_rw = 1'b1;
        if (w_lw)         w_m2r  = 2'b01;
        else if (w_rtype) w_rdst = 2'b01;
      end
      S_HALT: w_hlt = 1'b1;
      default: ;
    endcase
  end

  assign w_retire = (w_next == S_IF) &&
                    ((r_state == S_EX) || (r_state == S_MEM) || (r_state == S_WB));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IF;
      retired  <= '0;
      PCSrc    <= '0;
      ALUSrcA  <= 1'b0;
      ALUSrcB  <= 2'b01;
      lorD     <= 1'b0;
      MemRead  <= 1'b1;
      MemWrite <= 1'b0;
      MemtoReg <= '0;
      RegDst   <= '0;
      IRWrite  <= 1'b0;
      RegWrite <= 1'b0;
      PCWrite  <= 1'b0;
      Branch   <= 1'b0;
      ExtSel   <= 1'b0;
      Zero_Ctr <= 1'b0;
      ALUop    <= '0;
      Funct_im <= '0;
      halted   <= 1'b0;
    end else begin
      r_state  <= w_next;
      if (w_retire) retired <= retired + CNT_W'(1);
      PCSrc    <= w_pcsrc;
      ALUSrcA  <= w_asa;
      ALUSrcB  <= w_asb;
      lorD     <= w_lord;
      MemRead  <= w_mr;
      MemWrite <= w_mw;
      MemtoReg <= w_m2r;
      RegDst   <= w_rdst;
      IRWrite  <= w_irw;
      RegWrite <= w_rw;
      PCWrite  <= w_pcw;
      Branch   <= w_br;
      ExtSel   <= w_ext;
      Zero_Ctr <= w_zc;
      ALUop    <= w_aluop;
      Funct_im <= w_fim;
      halted   <= w_hlt;
    end
  end

  assign state = r_state;

endmodule
